// File: rtl/bus_slave_pkg.sv
// Shared types and constants for the bus write slave and its stream FIFO.
package bus_slave_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_PUSH  = 2'd1;
  localparam logic [1:0] OFF_CLEAR = 2'd2;

  // Write request latched when a window hit is accepted.
  typedef struct packed {
    logic [1:0]        off;
    logic [DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with clear; count is one bit wider than the pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  // Clear overrides any push/pop in the same cycle.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/bus_write_slave.sv
// Memory-mapped write responder: 16-byte window, programmable wait states,
// control register, stream FIFO and sticky error flag.
module bus_write_slave
  import bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           ADDR_BUS,
  input  logic [DATA_W-1:0]           DATA_WBUS,
  input  logic                        BUS_VALID,
  output logic                        SLAVE_READY,
  output logic [DATA_W-1:0]           CTRL_OUT,
  output logic [DATA_W-1:0]           FIFO_DATA,
  output logic                        FIFO_VALID,
  input  logic                        FIFO_READY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        ERR_STICKY
);

  state_e             state_q, state_d;
  wreq_t              req_q, req_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  ctrl_q, ctrl_d;
  logic               err_q, err_d;
  logic               hit_c, push_c, pop_c, clear_c;
  logic               fifo_full, fifo_empty;
  logic               unused_addr_lsb;

  assign hit_c           = BUS_VALID && (ADDR_BUS[31:4] == BASE_ADDR[31:4]);
  assign unused_addr_lsb = ^ADDR_BUS[1:0];
  assign pop_c           = FIFO_READY && !fifo_empty;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wcnt_d  = wcnt_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    push_c  = 1'b0;
    clear_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit_c) begin
          req_d.off  = ADDR_BUS[3:2];
          req_d.data = DATA_WBUS;
          wcnt_d     = WCNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES != 0)
            state_d = WAIT;
          else if ((ADDR_BUS[3:2] == OFF_PUSH) && fifo_full)
            state_d = STALL;
          else
            state_d = ACK;
        end
      end
      // Leaves after WAIT_CYCLES cycles; full check uses the registered count.
      WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q <= WCNT_W'(1))
          state_d = ((req_q.off == OFF_PUSH) && fifo_full) ? STALL : ACK;
      end
      STALL: begin
        if (!fifo_full) state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
        case (req_q.off)
          OFF_CTRL:  ctrl_d  = req_q.data;
          OFF_PUSH:  push_c  = 1'b1;
          OFF_CLEAR: clear_c = 1'b1;
          default:   err_d   = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .clear_i (clear_c),
    .din_i   (req_q.data),
    .dout_o  (FIFO_DATA),
    .count_o (FIFO_COUNT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign SLAVE_READY = ready_q;
  assign CTRL_OUT    = ctrl_q;
  assign ERR_STICKY  = err_q;
  assign FIFO_VALID  = !fifo_empty;

endmodule

// File: tb/tb_bus_write_slave.sv
// Bench for bus_write_slave: two instances (0 and 3 wait states) driven by
// directed and random writes, checked against a queue-based register model.
module tb_bus_write_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        valid [2];
  logic        fready [2];
  logic        sready [2];
  logic [31:0] ctrl [2];
  logic [31:0] fdata [2];
  logic        fvalid [2];
  logic [2:0]  fcount [2];
  logic        err [2];

  int          waitc [2];
  logic [31:0] ctrl_m [2];
  logic        err_m [2];
  logic [31:0] q_m [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bus_write_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .ADDR_BUS(addr[0]), .DATA_WBUS(wdata[0]),
    .BUS_VALID(valid[0]), .SLAVE_READY(sready[0]), .CTRL_OUT(ctrl[0]),
    .FIFO_DATA(fdata[0]), .FIFO_VALID(fvalid[0]), .FIFO_READY(fready[0]),
    .FIFO_COUNT(fcount[0]), .ERR_STICKY(err[0]));

  bus_write_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(3), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .ADDR_BUS(addr[1]), .DATA_WBUS(wdata[1]),
    .BUS_VALID(valid[1]), .SLAVE_READY(sready[1]), .CTRL_OUT(ctrl[1]),
    .FIFO_DATA(fdata[1]), .FIFO_VALID(fvalid[1]), .FIFO_READY(fready[1]),
    .FIFO_COUNT(fcount[1]), .ERR_STICKY(err[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-map semantics; instance 0 only ever receives CTRL/undefined/miss.
  task automatic apply(input int sel, input logic [31:0] a, input logic [31:0] d);
    if ((a >> 4) != (BASE >> 4)) return;
    case ((a >> 2) & 32'd3)
      32'd0: ctrl_m[sel] = d;
      32'd1: if (sel == 1) q_m.push_back(d);
      32'd2: if (sel == 1) q_m.delete();
      default: err_m[sel] = 1'b1;
    endcase
  endtask

  task automatic check_state(input int sel);
    check("ctrl", ctrl[sel], ctrl_m[sel]);
    check("err", 32'(err[sel]), 32'(err_m[sel]));
    if (sel == 1) begin
      check("count", 32'(fcount[1]), 32'(q_m.size()));
      check("fvalid", 32'(fvalid[1]), 32'(q_m.size() != 0));
      if (q_m.size() != 0) check("head", fdata[1], q_m[0]);
    end else begin
      check("count_a", 32'(fcount[0]), 32'd0);
    end
  endtask

  // Issue a write in the current cycle, wait for the acknowledge, then
  // release the bus; optionally pop the FIFO in the acknowledge cycle.
  task automatic do_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                          input bit pop_on_ack);
    int cyc;
    bit seen;
    valid[sel] = 1'b1;
    addr[sel]  = a;
    wdata[sel] = d;
    seen = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (sready[sel]) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      check("ack_timeout", 32'd0, 32'd1);
      valid[sel] = 1'b0;
      return;
    end
    check("latency", 32'(cyc), 32'(2 + waitc[sel]));
    if (pop_on_ack) begin
      fready[sel] = 1'b1;
      if (sel == 1 && q_m.size() != 0) void'(q_m.pop_front());
    end
    apply(sel, a, d);
    tick();
    valid[sel]  = 1'b0;
    fready[sel] = 1'b0;
    addr[sel]   = $urandom;
    wdata[sel]  = $urandom;
    check("ready_pulse", 32'(sready[sel]), 32'd0);
    check_state(sel);
  endtask

  task automatic miss_hold(input int sel, input logic [31:0] a, input int n);
    valid[sel] = 1'b1;
    addr[sel]  = a;
    wdata[sel] = $urandom;
    for (int i = 0; i < n; i++) begin
      tick();
      check("miss_ready", 32'(sready[sel]), 32'd0);
    end
    valid[sel] = 1'b0;
    tick();
    check_state(sel);
  endtask

  task automatic pop_cycle();
    fready[1] = 1'b1;
    tick();
    fready[1] = 1'b0;
    if (q_m.size() != 0) void'(q_m.pop_front());
    check_state(1);
  endtask

  initial begin
    waitc[0] = 0;
    waitc[1] = 3;
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; wdata[s] = '0; valid[s] = 1'b0; fready[s] = 1'b0;
      ctrl_m[s] = '0; err_m[s] = 1'b0;
    end
    rst_n = 1'b0;
    tick(); tick();
    check("rst_ready_a", 32'(sready[0]), 32'd0);
    check("rst_ready_b", 32'(sready[1]), 32'd0);
    check_state(0);
    check_state(1);
    rst_n = 1'b1;
    tick();

    // Zero-wait CTRL write, then a miss and an undefined offset.
    do_write(0, 32'h0000_1000, 32'hA5A5_0001, 1'b0);
    miss_hold(0, 32'h0000_2000, 8);
    do_write(0, 32'h0000_100C, 32'h0BAD_0BAD, 1'b0);

    // Three wait states on a PUSH.
    do_write(1, 32'h0000_1004, 32'h0000_0011, 1'b0);
    do_write(1, 32'h0000_1008, 32'hFFFF_FFFF, 1'b0);

    // Fill the FIFO, then a fifth push must stall until one pop frees space.
    for (int i = 1; i <= 4; i++) do_write(1, 32'h0000_1004, 32'(i), 1'b0);
    valid[1] = 1'b1;
    addr[1]  = 32'h0000_1004;
    wdata[1] = 32'h0000_0005;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ready", 32'(sready[1]), 32'd0);
    end
    check("stall_count", 32'(fcount[1]), 32'd4);
    fready[1] = 1'b1;
    tick();
    fready[1] = 1'b0;
    void'(q_m.pop_front());
    check("pop_head", fdata[1], 32'h0000_0002);
    check("pop_count", 32'(fcount[1]), 32'd3);
    check("stall_ready2", 32'(sready[1]), 32'd0);
    tick();
    check("stall_ack", 32'(sready[1]), 32'd1);
    apply(1, 32'h0000_1004, 32'h0000_0005);
    tick();
    valid[1] = 1'b0;
    check_state(1);
    fready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain", fdata[1], q_m.pop_front());
      tick();
    end
    fready[1] = 1'b0;
    check_state(1);

    // Miss and undefined offset on the waited instance.
    miss_hold(1, 32'h0000_2000, 8);
    do_write(1, 32'h0000_100C, 32'h1234_0000, 1'b0);

    // CLEAR committing in the same edge as a consumer pop.
    for (int i = 0; i < 3; i++) do_write(1, 32'h0000_1004, $urandom, 1'b0);
    do_write(1, 32'h0000_1008, $urandom, 1'b1);

    // Random mix of operations and consumer pops.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 6);
      if (r == 6) begin
        a = $urandom;
        if ((a >> 4) == (BASE >> 4)) a = a ^ 32'h8000_0000;
        miss_hold(1, a, 3);
      end else if (r == 5) begin
        pop_cycle();
      end else begin
        logic [1:0] off;
        off = 2'($urandom_range(0, 3));
        if (r <= 2) off = 2'd1;
        if (off == 2'd1 && q_m.size() == DEPTH) off = 2'd2;
        a = BASE | (32'(off) << 2) | 32'($urandom_range(0, 3));
        do_write(1, a, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    // Reset during the wait phase of a CTRL write; the re-issue completes.
    do_write(1, 32'h0000_1000, 32'h1234_5678, 1'b0);
    valid[1] = 1'b1;
    addr[1]  = 32'h0000_1000;
    wdata[1] = 32'hDEAD_BEEF;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    ctrl_m[0] = '0; ctrl_m[1] = '0; err_m[0] = 1'b0; err_m[1] = 1'b0;
    q_m.delete();
    check("rst_mid_ready", 32'(sready[1]), 32'd0);
    check_state(0);
    check_state(1);
    valid[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_write(1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    do_write(0, 32'h0000_1000, 32'h0000_00C3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_write_slave.md
Name: bus_write_slave

Overview:
- Memory-mapped write responder for the core's bus master port (ADDR_BUS / DATA_WBUS / BUS_VALID / SLAVE_READY).
- Decodes a 16-byte window and inserts programmable wait states.
- Drives a 32-bit control output register.
- Pushes stream data into a small FIFO drained by a downstream consumer over valid/ready.
- Answers only addresses inside its window, so other slaves can share the bus.

Parameters:
- BASE_ADDR, 32'h0000_1000: window base; must be 16-byte aligned.
- WAIT_CYCLES, 0: extra cycles between capture and acknowledge; range 0..15.
- FIFO_DEPTH, 4: stream FIFO entries; power of two, at least 2.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- ADDR_BUS  in  32: byte address from the master.
- DATA_WBUS  in  32: write data from the master.
- BUS_VALID  in  1: master request; addr and data are stable while high and not yet acknowledged.
- SLAVE_READY  out  1: one-cycle acknowledge of a completed write.
- CTRL_OUT  out  32: control register contents.
- FIFO_DATA  out  32: head entry of the FIFO.
- FIFO_VALID  out  1: FIFO is non-empty.
- FIFO_READY  in  1: consumer pop strobe.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1: current occupancy.
- ERR_STICKY  out  1: set by a write to an undefined offset inside the window.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - SLAVE_READY, CTRL_OUT, FIFO_COUNT, FIFO_VALID and ERR_STICKY = 0.
  - FIFO pointers = 0.
  - Reset takes effect mid-transfer with no completion; the master must re-issue the write.
- Hit: BUS_VALID & (ADDR_BUS[31:4] == BASE_ADDR[31:4]). Offset = ADDR_BUS[3:2]; ADDR_BUS[1:0] is ignored.
- Register map:
  - Offset 0, CTRL: CTRL_OUT <= data.
  - Offset 1, PUSH: write data into the FIFO.
  - Offset 2, CLEAR: empty the FIFO; data is ignored.
  - Offset 3: undefined. The write is acknowledged, no state changes, ERR_STICKY <= 1.
  - ERR_STICKY clears only on reset.
- FSM states: IDLE, WAIT, STALL, ACK.
- IDLE:
  - On a hit, capture addr and data into internal latches and load wcnt = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise the commit state (see WAIT).
  - A miss stays in IDLE with SLAVE_READY = 0.
- WAIT:
  - Decrement wcnt each cycle.
  - When wcnt reaches 0 (or immediately if WAIT_CYCLES = 0), go to STALL if the captured op is PUSH and FIFO_COUNT == FIFO_DEPTH; otherwise go to ACK.
- STALL: hold until FIFO_COUNT < FIFO_DEPTH, as registered at the start of the cycle, then go to ACK.
- ACK:
  - SLAVE_READY = 1 for exactly this cycle.
  - The side effect (CTRL update, push or clear) is committed at the clock edge that ends ACK.
  - Next state is IDLE.
- Cycle counts:
  - With WAIT_CYCLES = 0, SLAVE_READY is high in the second cycle after the request is sampled.
  - Minimum back-to-back transfer is 2 cycles (IDLE, ACK).
  - In general, SLAVE_READY is high in cycle 2+WAIT_CYCLES, plus any STALL cycles.
- Master obligations:
  - Hold BUS_VALID, addr and data until SLAVE_READY has been seen.
  - In the cycle after ACK, BUS_VALID may be low or may carry a new request. The slave re-samples in IDLE.
  - Changes to addr/data after capture are ignored.
- FIFO:
  - FIFO_DATA is the head entry, valid when FIFO_VALID = 1.
  - Pop occurs when FIFO_VALID & FIFO_READY at a clock edge.
  - A pop while empty has no effect.
  - Push and pop in the same edge: count unchanged, data order preserved.
  - Full FIFO with a simultaneous pop: the push waits one extra STALL cycle (count is evaluated registered).
  - CLEAR coinciding with a pop: CLEAR wins; count = 0 and the pointers reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic: the count is one bit wider than the pointers so that full and empty are distinguishable.

Decomposition:
- Package bus_slave_pkg holds:
  - state enum (IDLE/WAIT/STALL/ACK);
  - offset constants OFF_CTRL=2'd0, OFF_PUSH=2'd1, OFF_CLEAR=2'd2;
  - WAIT counter width constant (4).
- Sub-module sync_fifo:
  - parameterised width and depth;
  - ports push, pop, clear, dout, count, full, empty.
- The FSM and decode stay in bus_write_slave.

Test Plan:
- Reset, then write 0xA5A5_0001 to 0x1000 with WAIT_CYCLES=0 -> SLAVE_READY high in cycle 2 for exactly 1 cycle; CTRL_OUT = 0xA5A5_0001 afterwards.
- WAIT_CYCLES=3; write to 0x1004 with data 0x11 -> SLAVE_READY in cycle 5; FIFO_COUNT = 1; FIFO_VALID = 1; FIFO_DATA = 0x11.
- Push 0x1..0x4 (full), FIFO_READY=0, then push 0x5 -> slave sits in STALL with SLAVE_READY low. Pulse FIFO_READY once -> head becomes 0x2; 0x5 is accepted one cycle later; draining yields the order 2,3,4,5.
- Write to 0x2000 with BUS_VALID held high -> SLAVE_READY never asserts and no state changes. Write to 0x100C -> acknowledged, ERR_STICKY = 1.
- Fill 3 entries, then write to 0x1008 in the same cycle that FIFO_READY pops -> FIFO_COUNT = 0 and FIFO_VALID = 0 after ACK.
- Drop rst_n during WAIT of a CTRL write -> SLAVE_READY = 0 immediately, CTRL_OUT = 0. After release, a re-issued write completes normally.
